// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared constants and helpers for the decode stage:
//   - 5-bit major opcode constants (insn[6:2])
//   - funct7 constants used for OP / OP-32 legality and M-extension detection
//   - alu_op encodings ({insn[30], funct3} style, 4 bits)
//   - immediate format selection and 32-bit immediate assembly helpers
// ----------------------------------------------------------------------------
package decode_pkg;

    // Major opcodes, insn[6:2]
    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // alu_op encodings: bit 3 is insn[30] (sub / arithmetic shift), bits 2:0 funct3
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Immediate format is a pure function of the major opcode.
    function automatic imm_fmt_e imm_fmt(input logic [4:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                      fmt = IMM_U;
            OPC_JAL:                                 fmt = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_SYSTEM, OPC_OP_IMM_32:               fmt = IMM_I;
            OPC_STORE:                               fmt = IMM_S;
            OPC_BRANCH:                              fmt = IMM_B;
            default:                                 fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // Assembles the 32-bit sign-correct immediate; the caller widens it to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] insn, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm = {insn[31:12], 12'b0};
            IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// ----------------------------------------------------------------------------
// decode_comb
// Purely combinational instruction decoder.
//   insn     in   32    instruction word
//   opcode   out  5     insn[6:2]
//   rd       out  5     insn[11:7]
//   rs1      out  5     insn[19:15]
//   rs2      out  5     insn[24:20]
//   alu_op   out  4     ALU operation encoding
//   muldiv   out  1     M-extension operation (only with DECODE_M_EXT_EN)
//   imm      out  XLEN  sign-extended immediate
//   illegal  out  1     instruction not supported by this XLEN/configuration
// Build option: define DECODE_M_EXT_EN to accept funct7==0000001 on OP
// (and OP-32 for XLEN==64) as multiply/divide; otherwise those are illegal.
// ----------------------------------------------------------------------------
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     insn,
    output logic [4:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [3:0]      alu_op,
    output logic            muldiv,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_narrow;

    assign opcode = insn[6:2];
    assign rd     = insn[11:7];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct3 = insn[14:12];
    assign funct7 = insn[31:25];

    assign imm_narrow = imm32(insn, imm_fmt(opcode));
    // Signed size cast replicates bit 31 up to XLEN (no-op when XLEN==32).
    assign imm = XLEN'($signed(imm_narrow));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        illegal = (insn[1:0] != 2'b11);
        muldiv  = 1'b0;
        alu_op  = {1'b0, funct3};

        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: begin
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b111) illegal = 1'b1;
                if (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110)) illegal = 1'b1;
            end
            OPC_STORE: begin
                if (funct3[2]) illegal = 1'b1;
                if (!RV64 && funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (opcode == OPC_OP_IMM_32 && !RV64) illegal = 1'b1;
                // Shift-right immediates carry the arithmetic/logical select in insn[30].
                if (funct3 == 3'b101) alu_op = {insn[30], funct3};
            end
            OPC_OP, OPC_OP_32: begin
                if (opcode == OPC_OP_32 && !RV64) illegal = 1'b1;
                alu_op = {insn[30], funct3};
                if (funct7 == F7_MULDIV) begin
`ifdef DECODE_M_EXT_EN
                    if (opcode == OPC_OP || RV64) begin
                        muldiv = 1'b1;
                        alu_op = {1'b0, funct3};
                    end
`else
                    illegal = 1'b1;
`endif
                end else if (!(funct7 == F7_BASE ||
                               (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Decode pipeline stage: a DEPTH-entry FIFO of raw (insn, pc) pairs with
// valid/ready handshakes on both sides. The head entry is decoded
// combinationally from registered storage, so an entry accepted on one edge
// is visible on out_* right after that edge, and no input reaches an output
// without passing through a register.
//   clk         in   1     clock, rising edge
//   rst         in   1     asynchronous active-high reset (drops all entries)
//   flush       in   1     synchronous discard of all entries (wins over push/pop)
//   in_valid    in   1     input handshake
//   in_ready    out  1     count < DEPTH
//   in_insn     in   32    instruction word
//   in_pc       in   XLEN  instruction address
//   out_valid   out  1     head entry present
//   out_ready   in   1     consumer accepts head entry
//   out_pc      out  XLEN
//   out_opcode  out  5     insn[6:2]
//   out_rd/out_rs1/out_rs2 out 5 each
//   out_alu_op  out  4
//   out_muldiv  out  1
//   out_imm     out  XLEN
//   out_illegal out  1
// Build option: DECODE_M_EXT_EN (see decode_comb).
// ----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [3:0]      out_alu_op,
    output logic            out_muldiv,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [31:0]     insn_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    logic [31:0] head_insn;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        // Explicit wrap so non-power-of-two depths stay inside the array.
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Both handshake flags come from registered count only.
    assign in_ready  = (count < CNT_DEPTH);
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; validity is carried entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            insn_mem[wr_ptr] <= in_insn;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    assign head_insn = insn_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .insn    (head_insn),
        .opcode  (out_opcode),
        .rd      (out_rd),
        .rs1     (out_rs1),
        .rs2     (out_rs2),
        .alu_op  (out_alu_op),
        .muldiv  (out_muldiv),
        .imm     (out_imm),
        .illegal (out_illegal)
    );

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Drives one XLEN=32 and one XLEN=64 decode_stage (both DEPTH=2) with the same
// stimulus. Expected decodes come from an instruction-level reference model
// and are queued when an input transfer happens; per-DUT monitors compare the
// head entry on every falling edge and retire it when it is transferred out.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_op;
        logic        muldiv;
        logic [63:0] imm;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_muldiv32, out_illegal32;
    logic [31:0] out_pc32, out_imm32;
    logic [4:0]  out_opcode32, out_rd32, out_rs1_32, out_rs2_32;
    logic [3:0]  out_alu_op32;

    logic        in_ready64, out_valid64, out_muldiv64, out_illegal64;
    logic [63:0] out_pc64, out_imm64;
    logic [4:0]  out_opcode64, out_rd64, out_rs1_64, out_rs2_64;
    logic [3:0]  out_alu_op64;

    exp_t act32, act64;
    exp_t q32[$];
    exp_t q64[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_insn     (in_insn),
        .in_pc       (in_pc[31:0]),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_pc      (out_pc32),
        .out_opcode  (out_opcode32),
        .out_rd      (out_rd32),
        .out_rs1     (out_rs1_32),
        .out_rs2     (out_rs2_32),
        .out_alu_op  (out_alu_op32),
        .out_muldiv  (out_muldiv32),
        .out_imm     (out_imm32),
        .out_illegal (out_illegal32)
    );

    decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_pc      (out_pc64),
        .out_opcode  (out_opcode64),
        .out_rd      (out_rd64),
        .out_rs1     (out_rs1_64),
        .out_rs2     (out_rs2_64),
        .out_alu_op  (out_alu_op64),
        .out_muldiv  (out_muldiv64),
        .out_imm     (out_imm64),
        .out_illegal (out_illegal64)
    );

    always_comb begin
        act32.pc      = {32'b0, out_pc32};
        act32.opcode  = out_opcode32;
        act32.rd      = out_rd32;
        act32.rs1     = out_rs1_32;
        act32.rs2     = out_rs2_32;
        act32.alu_op  = out_alu_op32;
        act32.muldiv  = out_muldiv32;
        act32.imm     = {32'b0, out_imm32};
        act32.illegal = out_illegal32;
        act64.pc      = out_pc64;
        act64.opcode  = out_opcode64;
        act64.rd      = out_rd64;
        act64.rs1     = out_rs1_64;
        act64.rs2     = out_rs2_64;
        act64.alu_op  = out_alu_op64;
        act64.muldiv  = out_muldiv64;
        act64.imm     = out_imm64;
        act64.illegal = out_illegal64;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t a, input exp_t e);
        check({tag, ".pc"},      a.pc,      e.pc);
        check({tag, ".opcode"},  a.opcode,  e.opcode);
        check({tag, ".rd"},      a.rd,      e.rd);
        check({tag, ".rs1"},     a.rs1,     e.rs1);
        check({tag, ".rs2"},     a.rs2,     e.rs2);
        check({tag, ".alu_op"},  a.alu_op,  e.alu_op);
        check({tag, ".muldiv"},  a.muldiv,  e.muldiv);
        check({tag, ".imm"},     a.imm,     e.imm);
        check({tag, ".illegal"}, a.illegal, e.illegal);
    endtask

    // Instruction-level reference: what the ISA says this word means for a
    // machine of the given width.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc, input int xlen);
        exp_t               e;
        logic [4:0]         op;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [63:0] imm;
        bit                 rv64, known, mext, ill, md;
        logic [3:0]         alu;
`ifdef DECODE_M_EXT_EN
        mext = 1'b1;
`else
        mext = 1'b0;
`endif
        rv64 = (xlen == 64);
        op = w[6:2];
        f3 = w[14:12];
        f7 = w[31:25];

        case (op)
            5'h0D, 5'h05:                      imm = $signed(w[31:12]) * 64'sd4096;
            5'h1B:                             imm = $signed({w[31], w[19:12], w[20], w[30:21]}) * 64'sd2;
            5'h19, 5'h00, 5'h04, 5'h1C, 5'h06: imm = $signed(w[31:20]);
            5'h08:                             imm = $signed({w[31:25], w[11:7]});
            5'h18:                             imm = $signed({w[31], w[7], w[30:25], w[11:8]}) * 64'sd2;
            default:                           imm = 64'sd0;
        endcase

        case (op)
            5'h0D, 5'h05, 5'h1B, 5'h19, 5'h18, 5'h00,
            5'h08, 5'h04, 5'h0C, 5'h03, 5'h1C: known = 1'b1;
            5'h06, 5'h0E:                      known = rv64;
            default:                           known = 1'b0;
        endcase

        ill = (w[1:0] != 2'b11) || !known;
        md  = 1'b0;
        alu = {1'b0, f3};
        if (op == 5'h19 && f3 != 3'd0) ill = 1'b1;
        if (op == 5'h18 && (f3 == 3'd2 || f3 == 3'd3)) ill = 1'b1;
        if (op == 5'h00 && (f3 == 3'd7 || (!rv64 && (f3 == 3'd3 || f3 == 3'd6)))) ill = 1'b1;
        if (op == 5'h08 && (f3 >= 3'd4 || (!rv64 && f3 == 3'd3))) ill = 1'b1;
        if ((op == 5'h04 || op == 5'h06) && f3 == 3'd5) alu = {w[30], f3};
        if (op == 5'h0C || op == 5'h0E) begin
            alu = {w[30], f3};
            if (f7 == 7'd1) begin
                if (mext && (op == 5'h0C || rv64)) begin
                    md  = 1'b1;
                    alu = {1'b0, f3};
                end else begin
                    ill = 1'b1;
                end
            end else if (!(f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
                ill = 1'b1;
            end
        end

        e.pc      = rv64 ? pc : {32'b0, pc[31:0]};
        e.opcode  = op;
        e.rd      = w[11:7];
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.alu_op  = alu;
        e.muldiv  = md;
        e.imm     = rv64 ? imm : {32'b0, imm[31:0]};
        e.illegal = ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 13))
            0:  w[6:2] = 5'h0D;
            1:  w[6:2] = 5'h05;
            2:  w[6:2] = 5'h1B;
            3:  w[6:2] = 5'h19;
            4:  w[6:2] = 5'h18;
            5:  w[6:2] = 5'h00;
            6:  w[6:2] = 5'h08;
            7:  w[6:2] = 5'h04;
            8:  w[6:2] = 5'h0C;
            9:  w[6:2] = 5'h03;
            10: w[6:2] = 5'h1C;
            11: w[6:2] = 5'h06;
            12: w[6:2] = 5'h0E;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 15) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    // Inputs are applied just after a rising edge; just before the next edge
    // the transfer that edge will perform is recorded in the scoreboards.
    task automatic step(input logic v, input logic [31:0] insn, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        in_valid  = v;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        #7;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (v && in_ready32) q32.push_back(model(insn, pc, 32));
            if (v && in_ready64) q64.push_back(model(insn, pc, 64));
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("m32.valid", out_valid32, q32.size() != 0);
        check("m32.ready", in_ready32, q32.size() < DEPTH);
        if (out_valid32 && q32.size() != 0) begin
            cmp("m32", act32, q32[0]);
            if (out_ready && !flush && !rst) void'(q32.pop_front());
        end
    end

    always @(negedge clk) begin
        check("m64.valid", out_valid64, q64.size() != 0);
        check("m64.ready", in_ready64, q64.size() < DEPTH);
        if (out_valid64 && q64.size() != 0) begin
            cmp("m64", act64, q64[0]);
            if (out_ready && !flush && !rst) void'(q64.pop_front());
        end
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'h0;
        in_pc     = 64'h0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset.out_valid32", out_valid32, 1'b0);
        check("reset.in_ready32",  in_ready32,  1'b1);
        check("reset.out_valid64", out_valid64, 1'b0);
        check("reset.in_ready64",  in_ready64,  1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed decodes with a free-flowing consumer.
        step(1'b1, 32'hFFF0_0093, 64'h100, 1'b1, 1'b0);
        check("addi.valid",   out_valid32,   1'b1);
        check("addi.opcode",  out_opcode32,  5'b00100);
        check("addi.rd",      out_rd32,      5'd1);
        check("addi.rs1",     out_rs1_32,    5'd0);
        check("addi.imm",     out_imm32,     32'hFFFF_FFFF);
        check("addi.alu_op",  out_alu_op32,  4'b0000);
        check("addi.illegal", out_illegal32, 1'b0);

        step(1'b1, 32'h8000_02B7, 64'h104, 1'b1, 1'b0);
        check("lui.rd64",  out_rd64,  5'd5);
        check("lui.imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui.imm32", out_imm32, 32'h8000_0000);

        step(1'b1, 32'h0220_80B3, 64'h108, 1'b1, 1'b0);
`ifdef DECODE_M_EXT_EN
        check("mul.illegal", out_illegal32, 1'b0);
        check("mul.muldiv",  out_muldiv32,  1'b1);
`else
        check("mul.illegal", out_illegal32, 1'b1);
        check("mul.muldiv",  out_muldiv32,  1'b0);
`endif

        step(1'b1, 32'h0000_0010, 64'h10C, 1'b1, 1'b0);
        check("lowbits.illegal", out_illegal32, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure: two entries fill the buffer, the third waits.
        step(1'b1, 32'h0010_0093, 64'h200, 1'b0, 1'b0);
        check("bp.ready_after1", in_ready32, 1'b1);
        step(1'b1, 32'h0020_0113, 64'h204, 1'b0, 1'b0);
        check("bp.ready_after2", in_ready32, 1'b0);
        check("bp.ready64",      in_ready64, 1'b0);
        step(1'b1, 32'h0030_0193, 64'h208, 1'b0, 1'b0);
        check("bp.head", out_pc32, 32'h200);
        step(1'b1, 32'h0030_0193, 64'h208, 1'b1, 1'b0);
        step(1'b1, 32'h0030_0193, 64'h208, 1'b1, 1'b0);
        check("bp.head_after", out_pc32, 32'h208);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("bp.drained", out_valid32, 1'b0);

        // Flush with a full buffer and a push in the same cycle.
        step(1'b1, 32'h0000_0013, 64'h300, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 64'h304, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 64'h308, 1'b1, 1'b1);
        check("flush.out_valid32", out_valid32, 1'b0);
        check("flush.in_ready32",  in_ready32,  1'b1);
        check("flush.out_valid64", out_valid64, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with entries held.
        step(1'b1, 32'h0000_0013, 64'h400, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 64'h404, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst.out_valid32", out_valid32, 1'b0);
        check("arst.in_ready32",  in_ready32,  1'b1);
        check("arst.out_valid64", out_valid64, 1'b0);
        check("arst.in_ready64",  in_ready64,  1'b1);
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomised traffic with random backpressure and occasional flush.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_insn(), {$urandom, $urandom} & ~64'h3,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("end.out_valid32", out_valid32, 1'b0);
        check("end.out_valid64", out_valid64, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
